// File: rtl/dump_pkg.sv
// Shared types and constants for the debug dump UART transmitter.
package dump_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    NEXT_CHAR = 2'd1,
    WAIT_BYTE = 2'd2
  } state_e;

  localparam int         CHARS_PER_FRAME = 31;
  localparam logic [4:0] LAST_IDX        = 5'(CHARS_PER_FRAME - 1);
  localparam logic [4:0] CR_IDX          = 5'(CHARS_PER_FRAME - 2);

  localparam logic [7:0] SPACE   = 8'h20;
  localparam logic [7:0] CR      = 8'h0D;
  localparam logic [7:0] LF      = 8'h0A;
  localparam logic [7:0] ZERO    = 8'h30;
  localparam logic [7:0] A_UPPER = 8'h41;

endpackage

// File: rtl/dump_tx_uart.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit; done pulses
// during the final cycle of the stop bit so the next byte can follow immediately.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        STOP_BIT  = 4'd9;

  logic              active_q, active_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [3:0]        bit_q, bit_d;
  logic [8:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              bit_end;

  assign bit_end = active_q && (baud_q == BAUD_LAST);
  assign done    = bit_end && (bit_q == STOP_BIT);
  assign tx      = tx_q;

  always_comb begin
    active_d = active_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    if (!active_q) begin
      if (start) begin
        active_d = 1'b1;
        tx_d     = 1'b0;
        shift_d  = {1'b1, data};  // stop bit rides in behind the data
        baud_d   = '0;
        bit_d    = '0;
      end
    end else if (bit_end) begin
      baud_d = '0;
      if (bit_q == STOP_BIT) begin
        active_d = 1'b0;
        tx_d     = 1'b1;
        bit_d    = '0;
      end else begin
        tx_d    = shift_q[0];
        shift_d = {1'b1, shift_q[8:1]};
        bit_d   = bit_q + 4'd1;
      end
    end else begin
      baud_d = baud_q + BAUD_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      active_q <= active_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: rtl/dump_tx.sv
// Sends a 31-char ASCII hex dump of six snapshotted 16-bit debug words over a
// UART line each time trigger is seen while idle.
module dump_tx
  import dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic [15:0] in3,
  input  logic [15:0] in4,
  input  logic [15:0] in5,
  input  logic [15:0] in6,
  input  logic        trigger,
  output logic        tx,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [15:0] snap_q [6];
  logic [15:0] snap_d [6];
  logic        start;
  logic        byte_done;
  logic [7:0]  char_sel;
  logic [15:0] word;
  logic [4:0]  pos;
  logic [3:0]  nib;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return ZERO + {4'h0, n};
    else           return A_UPPER + {4'h0, n} - 8'd10;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (trigger) state_d = NEXT_CHAR;
      NEXT_CHAR: state_d = WAIT_BYTE;
      WAIT_BYTE: if (byte_done) state_d = (idx_q == LAST_IDX) ? IDLE : NEXT_CHAR;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != IDLE);
    start = (state_q == NEXT_CHAR);
  end

  always_comb begin
    idx_d  = idx_q;
    snap_d = snap_q;
    if (state_q == IDLE && trigger) begin
      idx_d     = '0;
      snap_d[0] = in1;
      snap_d[1] = in2;
      snap_d[2] = in3;
      snap_d[3] = in4;
      snap_d[4] = in5;
      snap_d[5] = in6;
    end else if (state_q == WAIT_BYTE && byte_done && idx_q < LAST_IDX) begin
      idx_d = idx_q + 5'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q <= '0;
      for (int i = 0; i < 6; i++) snap_q[i] <= '0;
    end else begin
      idx_q  <= idx_d;
      snap_q <= snap_d;
    end
  end

  // Each word spans 5 chars (4 digits + separator); find word and digit position.
  always_comb begin
    word = snap_q[0];
    pos  = idx_q;
    for (int w = 1; w < 6; w++) begin
      if (idx_q >= 5'(5 * w)) begin
        word = snap_q[w];
        pos  = idx_q - 5'(5 * w);
      end
    end
    case (pos[1:0])
      2'd0:    nib = word[15:12];
      2'd1:    nib = word[11:8];
      2'd2:    nib = word[7:4];
      default: nib = word[3:0];
    endcase
    if (idx_q == CR_IDX)        char_sel = CR;
    else if (idx_q == LAST_IDX) char_sel = LF;
    else if (pos == 5'd4)       char_sel = SPACE;
    else                        char_sel = hex_ascii(nib);
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clock(clock),
    .reset(reset),
    .start(start),
    .data (char_sel),
    .tx   (tx),
    .done (byte_done)
  );

endmodule
